// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared FIFO control types and width helper for the write/read-side schedulers.
package fifo_ctrl_pkg;

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    // Index/counter width that never collapses to zero bits.
    function automatic int unsigned cw(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-write-port signals of the write arbiter.
interface fifo_wr_arbiter_if
    import fifo_ctrl_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int OW = cw(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            ack;
    logic                          w_en;
    logic [DATA_WIDTH-1:0]         wdata;
    logic                          full;
    logic                          halffull;
    logic [OW-1:0]                 owner;
    logic                          busy;

    modport master (
        output req, req_data, req_last, full, halffull,
        input  ack, w_en, wdata, owner, busy
    );

    modport slave (
        input  req, req_data, req_last, full, halffull,
        output ack, w_en, wdata, owner, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin pick: first set bit of vec at or above start, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  vec,
    input  logic [IW-1:0] start,
    output logic [IW-1:0] idx,
    output logic          found
);
    int j;

    // Walk offsets from farthest to nearest so the nearest hit is the one kept.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(start) + k) % N;
            if (vec[j]) begin
                idx   = IW'(j);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-granular arbiter sharing one FIFO write port among NUM_REQ requesters.
module fifo_wr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int                 NUM_REQ    = 4,
    parameter int                 DATA_WIDTH = 8,
    parameter int                 MAX_BURST  = 4,
    parameter logic [NUM_REQ-1:0] PRIO_MASK  = NUM_REQ'(1)
) (
    input  logic            wclk,
    input  logic            wrst,
    fifo_wr_arbiter_if.slave bus
);
    localparam int OW = cw(NUM_REQ);
    localparam int BW = cw(MAX_BURST + 1);

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;

    logic [NUM_REQ-1:0]    elig;
    logic [OW-1:0]         pick_idx;
    logic                  pick_found;
    logic [OW-1:0]         owner_inc;
    logic [BW-1:0]         beat_inc;
    logic                  accept;
    logic [NUM_REQ-1:0]    ack;
    logic [DATA_WIDTH-1:0] wdata;

    assign elig = bus.req & (bus.halffull ? PRIO_MASK : {NUM_REQ{1'b1}});

    rr_pick #(.N(NUM_REQ), .IW(OW)) u_pick (
        .vec   (elig),
        .start (rr_ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign owner_inc = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign beat_inc  = beat_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        accept     = 1'b0;
        ack        = '0;
        wdata      = '0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                // full freezes the burst; otherwise a dropped req is an abandon.
                if (!bus.full) begin
                    if (bus.req[owner_q]) begin
                        accept       = 1'b1;
                        ack[owner_q] = 1'b1;
                        wdata        = bus.req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
                        beat_cnt_d   = beat_inc;
                        if (bus.req_last[owner_q] || beat_inc == BW'(MAX_BURST)) begin
                            state_d  = IDLE;
                            rr_ptr_d = owner_inc;
                        end
                    end else begin
                        state_d  = IDLE;
                        rr_ptr_d = owner_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign bus.ack   = ack;
    assign bus.w_en  = accept;
    assign bus.wdata = wdata;
    assign bus.owner = owner_q;
    assign bus.busy  = (state_q == BURST);
endmodule
